boolean_expression_prio: RTL and testbench

- Registered 16-to-4 priority encoder.
- Samples a 16-bit request vector D each enabled clock and outputs the index of the highest-priority asserted bit on Y, with a valid flag.
- Sits between request-collecting logic and downstream arbitration/indexing logic that needs a registered, glitch-free index.

---
 rtl/boolean_expression_prio.sv | 53 +++++
 tb/tb_boolean_expression_prio.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/boolean_expression_prio.sv
// Registered 16-to-4 priority encoder with valid flag.
// LSB_PRIORITY selects whether the lowest or highest set bit wins.
module boolean_expression_prio #(
  parameter int LSB_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] D,
  output logic [3:0]  Y,
  output logic        valid
);

  logic [3:0] w_idx;
  logic       w_any;
  logic [3:0] r_y;
  logic       r_valid;

  assign w_any = |D;

  // Later loop iterations overwrite earlier ones, so scan order picks the winner
  generate
    if (LSB_PRIORITY != 0) begin : g_lsb
      always_comb begin
        w_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
          if (D[i]) w_idx = 4'(i);
        end
      end
    end else begin : g_msb
      always_comb begin
        w_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
          if (D[i]) w_idx = 4'(i);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= 4'd0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_y     <= w_idx;
      r_valid <= w_any;
    end
  end

  assign Y     = r_y;
  assign valid = r_valid;

endmodule

// File: tb/tb_boolean_expression_prio.sv
// Scoreboard bench for boolean_expression_prio.
// Both priority directions run side by side on shared stimulus.
module tb_boolean_expression_prio;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] D;
  logic [3:0]  y_msb, y_lsb;
  logic        v_msb, v_lsb;

  typedef struct {
    logic [3:0] y0;
    logic       v0;
    logic [3:0] y1;
    logic       v1;
    string      tag;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [3:0] m_y0 = 4'd0, m_y1 = 4'd0;
  logic       m_v0 = 1'b0, m_v1 = 1'b0;

  always #5 clk = ~clk;

  boolean_expression_prio #(.LSB_PRIORITY(0)) u_msb (
    .clk(clk), .rst(rst), .en(en), .D(D), .Y(y_msb), .valid(v_msb)
  );

  boolean_expression_prio #(.LSB_PRIORITY(1)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .D(D), .Y(y_lsb), .valid(v_lsb)
  );

  // Reference: collect the set positions, then take max or min.
  task automatic ref_enc(input logic [15:0] d,
                         output logic [3:0] hi, output logic [3:0] lo,
                         output logic any);
    int set_q[$];
    set_q = {};
    for (int i = 0; i < 16; i++) if (d[i]) set_q.push_back(i);
    any = (set_q.size() != 0);
    hi = 4'd0;
    lo = 4'd0;
    if (any) begin
      int mx[$];
      int mn[$];
      mx = set_q.max();
      mn = set_q.min();
      hi = 4'(mx[0]);
      lo = 4'(mn[0]);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [15:0] d,
                      input string tag);
    logic [3:0] hi, lo;
    logic       any;
    exp_t       x;
    @(negedge clk);
    rst = r;
    en  = e;
    D   = d;
    ref_enc(d, hi, lo, any);
    if (r) begin
      m_y0 = 4'd0; m_v0 = 1'b0;
      m_y1 = 4'd0; m_v1 = 1'b0;
    end else if (e) begin
      m_y0 = hi; m_v0 = any;
      m_y1 = lo; m_v1 = any;
    end
    x.y0 = m_y0; x.v0 = m_v0;
    x.y1 = m_y1; x.v1 = m_v1;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic cmp4(input string nm, input string tag,
                      input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d", nm, tag, act, req);
    end
  endtask

  task automatic cmp1(input string nm, input string tag,
                      input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got %b expected %b", nm, tag, act, req);
    end
  endtask

  // Monitor: one registered result per edge following each issued step
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp4("y_msb", e.tag, y_msb, e.y0);
      cmp1("valid_msb", e.tag, v_msb, e.v0);
      cmp4("y_lsb", e.tag, y_lsb, e.y1);
      cmp1("valid_lsb", e.tag, v_lsb, e.v1);
    end
  end

  logic [15:0] vec_tab [0:7];

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    D   = 16'hFFFF;

    step(1'b1, 1'b1, 16'hFFFF, "reset0");
    step(1'b1, 1'b1, 16'hFFFF, "reset1");
    step(1'b0, 1'b1, 16'hFFFF, "release");

    vec_tab[0] = 16'h0000; vec_tab[1] = 16'hFFFF;
    vec_tab[2] = 16'h000F; vec_tab[3] = 16'hF000;
    vec_tab[4] = 16'h9639; vec_tab[5] = 16'h69C6;
    vec_tab[6] = 16'h5A5A; vec_tab[7] = 16'hA5A5;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, vec_tab[i], "sweep");

    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'(1) << i, "walk1");

    step(1'b0, 1'b1, 16'h0100, "hold_cap");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h8000, "hold");
    step(1'b0, 1'b1, 16'h8000, "hold_rel");

    step(1'b0, 1'b1, 16'h1234, "pre_rst");
    step(1'b1, 1'b1, 16'h0040, "rst_vs_en");
    step(1'b0, 1'b1, 16'h0040, "post_rst");

    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      int k;
      k = $urandom_range(15, 0);
      case ($urandom_range(3, 0))
        0: d = 16'($urandom);
        1: d = (16'(1) << k) | (16'($urandom) & ((16'(1) << k) - 16'd1));
        2: d = (16'(1) << k) | (16'($urandom) & ~((16'(2) << k) - 16'd1));
        default: d = ($urandom_range(7, 0) == 0) ? 16'h0000 : (16'(1) << k);
      endcase
      step($urandom_range(19, 0) == 0, $urandom_range(3, 0) != 0, d, "rand");
    end

    begin
      int n;
      n = 0;
      while (sb.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      #2;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
